// File: rtl/serdesphy_ana_power_sequencer_if.sv
// Purpose: groups the request/status handshake between PHY control and the analog power sequencer.
// Latency: none, wires only.
// Backpressure: none; pwr_req is a level request and outputs are plain levels.
interface serdesphy_ana_power_sequencer_if;
    logic       pwr_req;
    logic       bias_ready;
    logic       pll_lock;
    logic       bias_en;
    logic       iso_en;
    logic       pll_en;
    logic       tx_en;
    logic       rx_en;
    logic       phy_ready;
    logic       seq_fault;
    logic [1:0] fault_code;
    logic [2:0] seq_state;

    // Control/analog side: drives requests and analog status, observes the enables.
    modport master (
        output pwr_req, bias_ready, pll_lock,
        input  bias_en, iso_en, pll_en, tx_en, rx_en, phy_ready, seq_fault, fault_code, seq_state
    );

    // Sequencer side.
    modport slave (
        input  pwr_req, bias_ready, pll_lock,
        output bias_en, iso_en, pll_en, tx_en, rx_en, phy_ready, seq_fault, fault_code, seq_state
    );
endinterface

// File: rtl/serdesphy_ana_power_sequencer.sv
// Purpose: sequences isolation release, bias, PLL and TX/RX enables; times out waits and supervises while active.
// Latency: Moore outputs change on the edge entering a state; pll_lock acts on the 3rd edge after it moves.
// Backpressure: none; pwr_req is a level, dropping it powers down (ignored while already in PDOWN).
module serdesphy_ana_power_sequencer #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned ISO_DLY  = 4,
    parameter int unsigned BIAS_TMO = 200,
    parameter int unsigned PLL_TMO  = 250,
    parameter int unsigned PD_DLY   = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    serdesphy_ana_power_sequencer_if.slave       pif
);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_ISO_REL   = 3'd1,
        ST_BIAS_WAIT = 3'd2,
        ST_PLL_WAIT  = 3'd3,
        ST_ACTIVE    = 3'd4,
        ST_PDOWN     = 3'd5,
        ST_FAULT     = 3'd6,
        ST_RSVD      = 3'd7
    } state_t;

    // Counter value seen on the last cycle of each timed phase.
    localparam logic [CNT_W-1:0] ISO_LAST  = CNT_W'(ISO_DLY - 1);
    localparam logic [CNT_W-1:0] BIAS_LAST = CNT_W'(BIAS_TMO - 1);
    localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_TMO - 1);
    localparam logic [CNT_W-1:0] PD_LAST   = CNT_W'(PD_DLY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fault_code_q, fault_code_d;
    logic             lock_meta_q, lock_s_q;

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pif.pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // State, phase counter and latched fault cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            cnt_q        <= '0;
            fault_code_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fault_code_q <= fault_code_d;
        end
    end

    // Next-state selection; within each state the checks are in priority order,
    // so a ready seen on the timeout cycle advances instead of faulting.
    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        unique case (state_q)
            ST_OFF: begin
                if (pif.pwr_req) state_d = ST_ISO_REL;
            end
            ST_ISO_REL: begin
                if (!pif.pwr_req)          state_d = ST_OFF;
                else if (cnt_q == ISO_LAST) state_d = ST_BIAS_WAIT;
            end
            ST_BIAS_WAIT: begin
                if (!pif.pwr_req)            state_d = ST_PDOWN;
                else if (pif.bias_ready)     state_d = ST_PLL_WAIT;
                else if (cnt_q == BIAS_LAST) begin
                    state_d      = ST_FAULT;
                    fault_code_d = 2'd1;
                end
            end
            ST_PLL_WAIT: begin
                if (!pif.pwr_req)           state_d = ST_PDOWN;
                else if (lock_s_q)          state_d = ST_ACTIVE;
                else if (cnt_q == PLL_LAST) begin
                    state_d      = ST_FAULT;
                    fault_code_d = 2'd2;
                end
            end
            ST_ACTIVE: begin
                if (!pif.pwr_req) state_d = ST_PDOWN;
                else if (!pif.bias_ready || !lock_s_q) begin
                    state_d      = ST_FAULT;
                    fault_code_d = 2'd3;
                end
            end
            ST_PDOWN: begin
                // Power-down always completes; a new request waits for OFF.
                if (cnt_q == PD_LAST) state_d = ST_OFF;
            end
            ST_FAULT: begin
                if (!pif.pwr_req) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
        if (state_d == ST_OFF) fault_code_d = 2'd0;
    end

    // Phase counter: restarts on any state change, saturates otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)  cnt_d = '0;
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end

    // Moore output decode from the registered state.
    always_comb begin
        pif.iso_en    = 1'b0;
        pif.bias_en   = 1'b0;
        pif.pll_en    = 1'b0;
        pif.tx_en     = 1'b0;
        pif.rx_en     = 1'b0;
        pif.phy_ready = 1'b0;
        pif.seq_fault = 1'b0;
        unique case (state_q)
            ST_OFF:       pif.iso_en = 1'b1;
            ST_ISO_REL:   ;
            ST_BIAS_WAIT: pif.bias_en = 1'b1;
            ST_PLL_WAIT: begin
                pif.bias_en = 1'b1;
                pif.pll_en  = 1'b1;
            end
            ST_ACTIVE: begin
                pif.bias_en   = 1'b1;
                pif.pll_en    = 1'b1;
                pif.tx_en     = 1'b1;
                pif.rx_en     = 1'b1;
                pif.phy_ready = 1'b1;
            end
            ST_PDOWN:     pif.bias_en = 1'b1;
            ST_FAULT: begin
                pif.iso_en    = 1'b1;
                pif.seq_fault = 1'b1;
            end
            default:      pif.iso_en = 1'b1;  // unused code behaves as OFF for its one cycle
        endcase
    end

    assign pif.fault_code = fault_code_q;
    assign pif.seq_state  = state_q;

endmodule

// File: tb/tb_serdesphy_ana_power_sequencer.sv
// Bench for the analog power sequencer: directed scenarios plus randomized segments against a phase/elapsed-time model.
module tb_serdesphy_ana_power_sequencer;

    localparam int ISO_DLY = 4, BIAS_TMO = 200, PLL_TMO = 250, PD_DLY = 4;
    localparam logic [11:0] V_RESET  = 12'b000_00_1000000;
    localparam logic [11:0] V_ACTIVE = 12'b100_00_0111110;
    localparam logic [11:0] V_PDOWN  = 12'b101_00_0100000;
    localparam logic [11:0] V_F1     = 12'b110_01_1000001;
    localparam logic [11:0] V_F3     = 12'b110_11_1000001;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    serdesphy_ana_power_sequencer_if pif();

    serdesphy_ana_power_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pif   (pif.slave)
    );

    always #5 clk = ~clk;

    // Reference model: phase number plus the edge on which it was entered;
    // time in phase is plain arithmetic on a free-running edge count.
    int         cyc     = 0;
    int         m_st    = 0;
    int         m_enter = 0;
    logic [1:0] m_code  = 2'd0;
    logic [1:0] lk_hist = 2'b00;   // pll_lock as sampled on the last two edges, [1] oldest
    int         m_el, m_nx;
    logic       m_ls;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_code = 2'd0; m_enter = cyc; lk_hist = 2'b00;
        end else begin
            cyc  = cyc + 1;
            m_el = cyc - m_enter - 1;       // full cycles already spent in the phase
            m_ls = lk_hist[1];
            m_nx = m_st;
            case (m_st)
                0: if (pif.pwr_req) m_nx = 1;
                1: if (!pif.pwr_req) m_nx = 0; else if (m_el == ISO_DLY - 1) m_nx = 2;
                2: if (!pif.pwr_req) m_nx = 5; else if (pif.bias_ready) m_nx = 3;
                   else if (m_el == BIAS_TMO - 1) begin m_nx = 6; m_code = 2'd1; end
                3: if (!pif.pwr_req) m_nx = 5; else if (m_ls) m_nx = 4;
                   else if (m_el == PLL_TMO - 1) begin m_nx = 6; m_code = 2'd2; end
                4: if (!pif.pwr_req) m_nx = 5;
                   else if (!pif.bias_ready || !m_ls) begin m_nx = 6; m_code = 2'd3; end
                5: if (m_el == PD_DLY - 1) m_nx = 0;
                6: if (!pif.pwr_req) m_nx = 0;
                default: m_nx = 0;
            endcase
            if (m_nx == 0) m_code = 2'd0;
            if (m_nx != m_st) m_enter = cyc;
            m_st    = m_nx;
            lk_hist = {lk_hist[0], pif.pll_lock};
        end
    end

    function automatic logic [11:0] mdl_vec();
        logic [6:0] o;   // {iso, bias, pll, tx, rx, ready, fault}
        case (m_st)
            1:       o = 7'b0000000;
            2:       o = 7'b0100000;
            3:       o = 7'b0110000;
            4:       o = 7'b0111110;
            5:       o = 7'b0100000;
            6:       o = 7'b1000001;
            default: o = 7'b1000000;
        endcase
        return {3'(m_st), m_code, o};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {pif.seq_state, pif.fault_code, pif.iso_en, pif.bias_en, pif.pll_en,
                pif.tx_en, pif.rx_en, pif.phy_ready, pif.seq_fault};
    endfunction

    // Bounded wait: number of falling edges until seq_state==s, or -1.
    task automatic wait_state(input logic [2:0] s, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (pif.seq_state == s) begin n = i; break; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; pif.pwr_req = 1'b0; pif.bias_ready = 1'b0; pif.pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic bring_up();
        int n;
        do_reset();
        pif.pwr_req = 1'b1; pif.bias_ready = 1'b1; pif.pll_lock = 1'b1;
        wait_state(3'd4, 40, n);
        checks++;
        if (n < 0) begin errors++; $display("FAIL bring_up: ACTIVE not reached, state=%0d", pif.seq_state); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        pif.pwr_req = 1'b0; pif.bias_ready = 1'b0; pif.pll_lock = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== V_RESET) begin errors++; $display("FAIL reset_outputs: got %b want %b", dut_vec(), V_RESET); end
        checks++;
        if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL reset_model: got %b want %b", dut_vec(), mdl_vec()); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dut_vec() !== V_RESET) begin errors++; $display("FAIL reset_idle: got %b want %b", dut_vec(), V_RESET); end
    endtask

    task automatic test_normal();
        int n;
        do_reset();
        pif.pwr_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({pif.seq_state, pif.iso_en, pif.bias_en} !== 5'b001_0_0) begin
            errors++; $display("FAIL normal_iso_rel: got %b want 00100", {pif.seq_state, pif.iso_en, pif.bias_en});
        end
        wait_state(3'd2, 10, n);
        checks++;
        if (n !== ISO_DLY) begin errors++; $display("FAIL normal_iso_len: got %0d want %0d", n, ISO_DLY); end
        checks++;
        if (pif.bias_en !== 1'b1 || pif.pll_en !== 1'b0) begin errors++; $display("FAIL normal_bias_en: got %b%b want 10", pif.bias_en, pif.pll_en); end
        repeat (97) @(negedge clk);
        pif.bias_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({pif.seq_state, pif.pll_en} !== 4'b011_1) begin errors++; $display("FAIL normal_pll_en: got %b want 0111", {pif.seq_state, pif.pll_en}); end
        repeat (40) @(negedge clk);
        #3 pif.pll_lock = 1'b1;
        wait_state(3'd4, 10, n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL normal_lock_latency: got %0d want 3", n); end
        checks++;
        if (dut_vec() !== V_ACTIVE) begin errors++; $display("FAIL normal_active: got %b want %b", dut_vec(), V_ACTIVE); end
    endtask

    task automatic test_bias_timeout();
        int n;
        do_reset();
        pif.pwr_req = 1'b1;
        wait_state(3'd2, 10, n);
        wait_state(3'd6, 300, n);
        checks++;
        if (n !== BIAS_TMO) begin errors++; $display("FAIL bias_tmo_len: got %0d want %0d", n, BIAS_TMO); end
        checks++;
        if (dut_vec() !== V_F1) begin errors++; $display("FAIL bias_tmo_outputs: got %b want %b", dut_vec(), V_F1); end
        repeat (5) @(negedge clk);
        checks++;
        if (dut_vec() !== V_F1) begin errors++; $display("FAIL fault_hold: got %b want %b", dut_vec(), V_F1); end
        pif.pwr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_vec() !== V_RESET) begin errors++; $display("FAIL fault_exit: got %b want %b", dut_vec(), V_RESET); end
    endtask

    task automatic test_boundary();
        int n;
        do_reset();
        pif.pwr_req = 1'b1;
        wait_state(3'd2, 10, n);
        repeat (BIAS_TMO - 1) @(negedge clk);
        pif.bias_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({pif.seq_state, pif.fault_code} !== 5'b011_00) begin
            errors++; $display("FAIL bias_last_cycle: got %b want 01100", {pif.seq_state, pif.fault_code});
        end
        repeat (PLL_TMO - 3) @(negedge clk);
        pif.pll_lock = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (pif.seq_state !== 3'd3) begin errors++; $display("FAIL pll_pre_last: got %0d want 3", pif.seq_state); end
        @(negedge clk);
        checks++;
        if (dut_vec() !== V_ACTIVE) begin errors++; $display("FAIL pll_last_cycle: got %b want %b", dut_vec(), V_ACTIVE); end
    endtask

    task automatic test_loss();
        int n;
        bring_up();
        #3 pif.pll_lock = 1'b0;
        wait_state(3'd6, 10, n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL lock_loss_latency: got %0d want 3", n); end
        checks++;
        if (dut_vec() !== V_F3) begin errors++; $display("FAIL lock_loss_outputs: got %b want %b", dut_vec(), V_F3); end
        bring_up();
        pif.bias_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_vec() !== V_F3) begin errors++; $display("FAIL bias_loss: got %b want %b", dut_vec(), V_F3); end
    endtask

    task automatic test_power_down();
        int n;
        bring_up();
        pif.pwr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_vec() !== V_PDOWN) begin errors++; $display("FAIL pdown_entry: got %b want %b", dut_vec(), V_PDOWN); end
        pif.pwr_req = 1'b1;
        wait_state(3'd0, 10, n);
        checks++;
        if (n !== PD_DLY) begin errors++; $display("FAIL pdown_len: got %0d want %0d", n, PD_DLY); end
        checks++;
        if (pif.iso_en !== 1'b1) begin errors++; $display("FAIL pdown_off_iso: got %b want 1", pif.iso_en); end
        @(negedge clk);
        checks++;
        if (pif.seq_state !== 3'd1) begin errors++; $display("FAIL pdown_rerequest: got %0d want 1", pif.seq_state); end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        pif.pwr_req = 1'b1; pif.bias_ready = 1'b1;
        wait_state(3'd3, 20, n);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== V_RESET) begin errors++; $display("FAIL async_reset: got %b want %b", dut_vec(), V_RESET); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pif.seq_state !== 3'd1) begin errors++; $display("FAIL async_restart: got %0d want 1", pif.seq_state); end
        wait_state(3'd2, 10, n);
        checks++;
        if (n !== ISO_DLY) begin errors++; $display("FAIL async_restart_iso: got %0d want %0d", n, ISO_DLY); end
    endtask

    task automatic test_random();
        int len, lk_at, d;
        logic lk_val;
        do_reset();
        for (int seg = 0; seg < 40; seg++) begin
            if ($urandom_range(0, 14) == 0) begin
                #1 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            pif.pwr_req    = ($urandom_range(0, 3) != 0);
            pif.bias_ready = 1'($urandom_range(0, 1));
            lk_val = 1'($urandom_range(0, 1));
            len    = $urandom_range(1, 260);
            lk_at  = $urandom_range(0, len - 1);
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    errors++; $display("FAIL random seg %0d cyc %0d: got %b want %b", seg, i, dut_vec(), mdl_vec());
                end
                if (i == lk_at) begin
                    d = $urandom_range(1, 3);
                    #(d) pif.pll_lock = lk_val;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pif.pwr_req = 1'b0; pif.bias_ready = 1'b0; pif.pll_lock = 1'b0;
        test_reset();
        test_normal();
        test_bias_timeout();
        test_boundary();
        test_loss();
        test_power_down();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
